lp_esc_tx: RTL

- Low-power escape-mode transmitter for one DSI data lane.
- Consumes the one-cycle `tick` pulse produced by the clock prescaler; each tick period is one LP symbol interval.
- Takes bytes over a valid/ready stream and drives the LP line pair (`lp_p`, `lp_n`).
- Frame order: escape entry sequence, entry command, payload with spaced-one-hot encoding, escape exit.

---
 rtl/lp_esc_tx.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/lp_esc_tx.sv
// Low-power escape-mode transmitter for one DSI data lane.
// Sends escape entry, an entry command, spaced-one-hot payload bytes and escape exit.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | LP-11, waiting for a payload byte on a tick
// RQ        | LP-10, escape request
// BR0       | LP-00, bridge
// BR1       | LP-01, bridge
// BR2       | LP-00, bridge, arms the command bit counter
// CMD_MARK  | mark for command bit CMD[bitcnt]
// CMD_SPACE | LP-00 space after a command mark
// DAT_MARK  | mark for payload bit shift[0]
// DAT_SPACE | LP-00 space after a payload mark; byte-accept point on bit 7
// EXIT      | LP-10, escape exit, then back to IDLE
module lp_esc_tx #(
    parameter logic [7:0] CMD = 8'hE1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    input  logic       in_last,
    output logic       in_ready,
    output logic       lp_p,
    output logic       lp_n,
    output logic       busy
);

    typedef enum logic [3:0] {
        IDLE,
        RQ,
        BR0,
        BR1,
        BR2,
        CMD_MARK,
        CMD_SPACE,
        DAT_MARK,
        DAT_SPACE,
        EXIT
    } state_t;

    state_t     state, state_nxt;
    logic [2:0] bitcnt, bitcnt_nxt;
    logic [7:0] shift, shift_nxt;
    logic       last_flag, last_nxt;
    logic       p_nxt, n_nxt;
    logic       accept_pt;

    assign accept_pt = (state == IDLE) ||
                       ((state == DAT_SPACE) && (bitcnt == 3'd7) && !last_flag);
    assign in_ready  = tick & accept_pt;

    always_comb begin
        state_nxt  = state;
        bitcnt_nxt = bitcnt;
        shift_nxt  = shift;
        last_nxt   = last_flag;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    shift_nxt = in_data;
                    last_nxt  = in_last;
                    state_nxt = RQ;
                end
            end
            RQ:  state_nxt = BR0;
            BR0: state_nxt = BR1;
            BR1: state_nxt = BR2;
            BR2: begin
                bitcnt_nxt = 3'd7;
                state_nxt  = CMD_MARK;
            end
            CMD_MARK: state_nxt = CMD_SPACE;
            CMD_SPACE: begin
                if (bitcnt == 3'd0) begin
                    state_nxt = DAT_MARK;
                end else begin
                    bitcnt_nxt = bitcnt - 3'd1;
                    state_nxt  = CMD_MARK;
                end
            end
            DAT_MARK: state_nxt = DAT_SPACE;
            DAT_SPACE: begin
                if (bitcnt != 3'd7) begin
                    shift_nxt  = {1'b0, shift[7:1]};
                    bitcnt_nxt = bitcnt + 3'd1;
                    state_nxt  = DAT_MARK;
                end else if (last_flag) begin
                    state_nxt = EXIT;
                end else if (in_valid) begin
                    shift_nxt  = in_data;
                    last_nxt   = in_last;
                    bitcnt_nxt = 3'd0;
                    state_nxt  = DAT_MARK;
                end
                // otherwise underrun: hold LP-00 and retry on the next tick
            end
            EXIT: begin
                bitcnt_nxt = 3'd0;
                last_nxt   = 1'b0;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Line value belongs to the state being entered, so outputs register with the state.
    always_comb begin
        p_nxt = 1'b0;
        n_nxt = 1'b0;
        case (state_nxt)
            IDLE: begin
                p_nxt = 1'b1;
                n_nxt = 1'b1;
            end
            RQ, EXIT: p_nxt = 1'b1;
            BR1:      n_nxt = 1'b1;
            CMD_MARK: begin
                p_nxt = CMD[bitcnt_nxt];
                n_nxt = ~CMD[bitcnt_nxt];
            end
            DAT_MARK: begin
                p_nxt = shift_nxt[0];
                n_nxt = ~shift_nxt[0];
            end
            default: begin
                p_nxt = 1'b0;
                n_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bitcnt    <= 3'd0;
            shift     <= 8'h00;
            last_flag <= 1'b0;
            lp_p      <= 1'b1;
            lp_n      <= 1'b1;
            busy      <= 1'b0;
        end else if (tick) begin
            state     <= state_nxt;
            bitcnt    <= bitcnt_nxt;
            shift     <= shift_nxt;
            last_flag <= last_nxt;
            lp_p      <= p_nxt;
            lp_n      <= n_nxt;
            busy      <= (state_nxt != IDLE);
        end
    end

endmodule
